// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game blocks (control, code_check, btn_debounce).
//   - cc_state_e     : code_check FSM state encoding
//   - CODE_W         : width of the secret code / player guess
//   - TRIES_W        : width of the remaining-attempts counter
//   - CLK_HZ         : system clock frequency
//   - MS_CYCLES      : clock cycles per millisecond
//   - tries_dec_sat  : saturating decrement of the attempts counter
//   - hint_of        : magnitude hint of a guess against the code
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned CODE_W    = 5;
    localparam int unsigned TRIES_W   = 3;
    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned MS_CYCLES = CLK_HZ / 1000;

    typedef enum logic [2:0] {
        CC_IDLE  = 3'd0,
        CC_ARMED = 3'd1,
        CC_CHECK = 3'd2,
        CC_WRONG = 3'd3,
        CC_WIN   = 3'd4,
        CC_LOSE  = 3'd5
    } cc_state_e;

    // Attempts never wrap below zero.
    function automatic logic [TRIES_W-1:0] tries_dec_sat(input logic [TRIES_W-1:0] tries);
        logic [TRIES_W-1:0] result;
        if (tries == 3'd0) begin
            result = 3'd0;
        end else begin
            result = tries - 3'd1;
        end
        return result;
    endfunction

    // 2'b01: guess below code, 2'b10: guess above code, 2'b00: equal.
    function automatic logic [1:0] hint_of(input logic [CODE_W-1:0] guess,
                                           input logic [CODE_W-1:0] secret);
        logic [1:0] result;
        if (guess < secret) begin
            result = 2'b01;
        end else if (guess > secret) begin
            result = 2'b10;
        end else begin
            result = 2'b00;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer, stable-sample counter and rising-edge pulse for a raw
// bouncing push button. The debounced level changes only after
// DEBOUNCE_CYCLES consecutive synchronized samples that differ from the
// current level; press is a single-cycle pulse on the debounced 0->1 change.
// Parameter:
//   DEBOUNCE_CYCLES : stable samples needed to accept a change (>= 1)
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  synchronous active-low reset (debounced level -> released)
//   btn   in  1  raw button, active-high, asynchronous
//   press out 1  one-cycle pulse on debounced press
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic        sync1_r;
    logic        sync2_r;
    logic        level_r;
    logic        press_r;
    logic [19:0] cnt_r;

    // Synchronize the raw button, count stable differing samples, emit press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= 20'd0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                // Any sample agreeing with the current level restarts the run.
                cnt_r   <= 20'd0;
                press_r <= 1'b0;
            end else if (cnt_r >= (DEBOUNCE_CYCLES - 20'd1)) begin
                // This sample completes the run of differing samples.
                level_r <= sync2_r;
                cnt_r   <= 20'd0;
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + 20'd1;
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/code_check.sv
// -----------------------------------------------------------------------------
// code_check
// Password entry/verification stage. Latches the secret code when the control
// block raises start_input, accepts guesses from the switches on a debounced
// confirm press and reports success or fail back to control. A wrong guess
// flashes the wrong output for FLASH_CYCLES; time_up forces a loss except once
// the code was already matched.
// Optional feature (macro CODE_CHECK_HINT_EN): adds output hint[1:0] telling
// whether the last wrong guess was below (2'b01) or above (2'b10) the code.
// Parameters:
//   MAX_TRIES       : wrong guesses allowed before fail (1..7)
//   DEBOUNCE_CYCLES : stable samples needed on the confirm button
//   FLASH_CYCLES    : length of the wrong-guess indication
// Ports:
//   clk         in  1  system clock
//   rst_n       in  1  synchronous active-low reset
//   start_input in  1  enable level from control; low forces IDLE
//   code        in  5  secret code, sampled on start_input rising edge
//   sw          in  5  player guess
//   btn_confirm in  1  raw confirm button, active-high, bouncing
//   time_up     in  1  countdown expired (level)
//   success     out 1  code matched, held until leave
//   fail        out 1  tries exhausted or timeout, held until leave
//   wrong       out 1  high for FLASH_CYCLES after a wrong guess
//   tries_left  out 3  remaining attempts
//   hint        out 2  (CODE_CHECK_HINT_EN only) last wrong-guess direction
// -----------------------------------------------------------------------------
module code_check
    import game_pkg::*;
#(
    parameter int unsigned MAX_TRIES       = 3,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] FLASH_CYCLES    = 24'd12500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_input,
    input  logic [CODE_W-1:0] code,
    input  logic [CODE_W-1:0] sw,
    input  logic              btn_confirm,
    input  logic              time_up,
    output logic              success,
    output logic              fail,
    output logic              wrong,
    output logic [TRIES_W-1:0] tries_left
`ifdef CODE_CHECK_HINT_EN
    ,
    output logic [1:0]        hint
`endif
);

    localparam logic [TRIES_W-1:0] MAX_TRIES_C = TRIES_W'(MAX_TRIES);

    cc_state_e           state_r;
    logic [CODE_W-1:0]   code_r;
    logic [CODE_W-1:0]   guess_r;
    logic [TRIES_W-1:0]  tries_r;
    logic [23:0]         flash_r;
    logic                start_d_r;
    logic                success_r;
    logic                fail_r;
    logic                wrong_r;

    logic                press_s;
    logic                start_rise_s;
    logic                guess_ok_s;
    logic [TRIES_W-1:0]  tries_dec_s;

`ifdef CODE_CHECK_HINT_EN
    logic [1:0]          hint_r;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_confirm),
        .press (press_s)
    );

    // start_d_r resets low, so a start_input already high out of reset is
    // seen as a rising edge on the first cycle.
    assign start_rise_s = start_input & ~start_d_r;
    assign guess_ok_s   = (guess_r == code_r);
    assign tries_dec_s  = tries_dec_sat(tries_r);

    // Game FSM: state, counters and registered outputs updated together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= CC_IDLE;
            code_r    <= 5'd0;
            guess_r   <= 5'd0;
            tries_r   <= MAX_TRIES_C;
            flash_r   <= 24'd0;
            start_d_r <= 1'b0;
            success_r <= 1'b0;
            fail_r    <= 1'b0;
            wrong_r   <= 1'b0;
`ifdef CODE_CHECK_HINT_EN
            hint_r    <= 2'b00;
`endif
        end else begin
            start_d_r <= start_input;
            if (!start_input) begin
                // Control withdrew the enable: abandon the round from any state.
                state_r   <= CC_IDLE;
                tries_r   <= MAX_TRIES_C;
                flash_r   <= 24'd0;
                success_r <= 1'b0;
                fail_r    <= 1'b0;
                wrong_r   <= 1'b0;
`ifdef CODE_CHECK_HINT_EN
                hint_r    <= 2'b00;
`endif
            end else begin
                case (state_r)
                    CC_IDLE: begin
                        tries_r   <= MAX_TRIES_C;
                        flash_r   <= 24'd0;
                        success_r <= 1'b0;
                        fail_r    <= 1'b0;
                        wrong_r   <= 1'b0;
`ifdef CODE_CHECK_HINT_EN
                        hint_r    <= 2'b00;
`endif
                        if (start_rise_s) begin
                            code_r  <= code;
                            state_r <= CC_ARMED;
                        end else begin
                            state_r <= CC_IDLE;
                        end
                    end

                    CC_ARMED: begin
                        // Timeout wins over a press arriving in the same cycle.
                        if (time_up) begin
                            state_r <= CC_LOSE;
                            fail_r  <= 1'b1;
                        end else if (press_s) begin
                            guess_r <= sw;
                            state_r <= CC_CHECK;
                        end else begin
                            state_r <= CC_ARMED;
                        end
                    end

                    CC_CHECK: begin
                        if (guess_ok_s) begin
                            state_r   <= CC_WIN;
                            success_r <= 1'b1;
                        end else begin
                            tries_r <= tries_dec_s;
`ifdef CODE_CHECK_HINT_EN
                            hint_r  <= hint_of(guess_r, code_r);
`endif
                            if (tries_dec_s == 3'd0) begin
                                state_r <= CC_LOSE;
                                fail_r  <= 1'b1;
                            end else begin
                                state_r <= CC_WRONG;
                                wrong_r <= 1'b1;
                                flash_r <= 24'd0;
                            end
                        end
                    end

                    CC_WRONG: begin
                        // Presses are ignored while the indication is showing.
                        if (time_up) begin
                            state_r <= CC_LOSE;
                            fail_r  <= 1'b1;
                            wrong_r <= 1'b0;
                            flash_r <= 24'd0;
`ifdef CODE_CHECK_HINT_EN
                            hint_r  <= 2'b00;
`endif
                        end else if (flash_r >= (FLASH_CYCLES - 24'd1)) begin
                            state_r <= CC_ARMED;
                            wrong_r <= 1'b0;
                            flash_r <= 24'd0;
`ifdef CODE_CHECK_HINT_EN
                            hint_r  <= 2'b00;
`endif
                        end else begin
                            state_r <= CC_WRONG;
                            flash_r <= flash_r + 24'd1;
                        end
                    end

                    CC_WIN: begin
                        // Terminal; time_up is deliberately ignored here.
                        state_r   <= CC_WIN;
                        success_r <= 1'b1;
                        fail_r    <= 1'b0;
                        wrong_r   <= 1'b0;
                    end

                    CC_LOSE: begin
                        state_r   <= CC_LOSE;
                        success_r <= 1'b0;
                        fail_r    <= 1'b1;
                        wrong_r   <= 1'b0;
                    end

                    default: begin
                        // Unreachable encoding: recover to a safe idle state.
                        state_r   <= CC_IDLE;
                        tries_r   <= MAX_TRIES_C;
                        flash_r   <= 24'd0;
                        success_r <= 1'b0;
                        fail_r    <= 1'b0;
                        wrong_r   <= 1'b0;
`ifdef CODE_CHECK_HINT_EN
                        hint_r    <= 2'b00;
`endif
                    end
                endcase
            end
        end
    end

    assign success    = success_r;
    assign fail       = fail_r;
    assign wrong      = wrong_r;
    assign tries_left = tries_r;
`ifdef CODE_CHECK_HINT_EN
    assign hint       = hint_r;
`endif

endmodule

// File: tb/tb_code_check.sv
module tb_code_check;

    logic       clk;
    logic       rst_n;
    logic       start_input;
    logic [4:0] code;
    logic [4:0] sw;
    logic       btn_confirm;
    logic       time_up;
    logic       success;
    logic       fail;
    logic       wrong;
    logic [2:0] tries_left;
`ifdef CODE_CHECK_HINT_EN
    logic [1:0] cc_hint;
`endif

    int checks;
    int errors;

    // Game-level reference model: rules only, no cycle structure.
    logic [4:0] m_code;
    int         m_tries;
    bit         m_done;

    typedef struct {
        logic       new_game;
        logic [4:0] code;
        logic [4:0] guess;
        logic       exp_success;
        logic       exp_fail;
        logic [2:0] exp_tries;
    } vec_t;

    vec_t tbl[6];

    int         dec_cnt;
    int         wr_rise;
    logic [2:0] prev_t;
    logic       prev_w;
    logic [4:0] rg;

    code_check #(
        .MAX_TRIES       (3),
        .DEBOUNCE_CYCLES (20'd4),
        .FLASH_CYCLES    (24'd8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_input (start_input),
        .code        (code),
        .sw          (sw),
        .btn_confirm (btn_confirm),
        .time_up     (time_up),
        .success     (success),
        .fail        (fail),
        .wrong       (wrong),
        .tries_left  (tries_left)
`ifdef CODE_CHECK_HINT_EN
        ,
        .hint        (cc_hint)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_game(input logic [4:0] c);
        start_input = 1'b0;
        time_up     = 1'b0;
        tick();
        code        = c;
        start_input = 1'b1;
        tick();
        code        = ~c;   // must already be latched
        m_code      = c;
        m_tries     = 3;
        m_done      = 1'b0;
        chk("start_tries", int'(tries_left), 3);
        chk("start_flags", int'({success, fail, wrong}), 0);
    endtask

    // Clean press: debounced edge lands 2 sync + 4 stable samples after the
    // button rises; the verdict is visible two edges after that.
    task automatic press_guess(input logic [4:0] g);
        logic exp_s;
        logic exp_f;
        logic exp_w;
        int   n;
        sw          = g;
        btn_confirm = 1'b1;
        repeat (6) tick();
        btn_confirm = 1'b0;
        tick();
        sw = ~g;            // guess must already be registered
        chk("check_cycle_flags", int'({success, fail}), 0);
        tick();
        exp_s = 1'b0;
        exp_f = 1'b0;
        exp_w = 1'b0;
        if (g == m_code) begin
            exp_s  = 1'b1;
            m_done = 1'b1;
        end else begin
            if (m_tries > 0) m_tries--;
            if (m_tries == 0) begin
                exp_f  = 1'b1;
                m_done = 1'b1;
            end else begin
                exp_w = 1'b1;
            end
        end
        chk("verdict_success", int'(success), int'(exp_s));
        chk("verdict_fail", int'(fail), int'(exp_f));
        chk("verdict_wrong", int'(wrong), int'(exp_w));
        chk("verdict_tries", int'(tries_left), m_tries);
`ifdef CODE_CHECK_HINT_EN
        if (exp_w) chk("hint_value", int'(cc_hint), (g < m_code) ? 1 : 2);
`endif
        if (exp_w) begin
            n = 0;
            while (wrong && n < 40) begin
                n++;
                tick();
            end
            chk("flash_length", n, 8);
`ifdef CODE_CHECK_HINT_EN
            chk("hint_cleared", int'(cc_hint), 0);
`endif
        end else begin
            repeat (8) tick();
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        start_input = 1'b1;
        code        = 5'b10110;
        sw          = 5'd0;
        btn_confirm = 1'b0;
        time_up     = 1'b0;

        // Reset state, with start_input already high.
        repeat (3) tick();
        chk("reset_flags", int'({success, fail, wrong}), 0);
        chk("reset_tries", int'(tries_left), 3);
        rst_n = 1'b1;
        tick();
        code    = 5'b00000;
        m_code  = 5'b10110;
        m_tries = 3;
        m_done  = 1'b0;
        press_guess(5'b10110);
        chk("start_high_from_reset_win", int'(success), 1);

        // Vector table: test plan items 1, 2 and 5.
        tbl[0] = '{1'b1, 5'b10110, 5'b10110, 1'b1, 1'b0, 3'd3};
        tbl[1] = '{1'b1, 5'b00011, 5'b00001, 1'b0, 1'b0, 3'd2};
        tbl[2] = '{1'b0, 5'b00011, 5'b11111, 1'b0, 1'b0, 3'd1};
        tbl[3] = '{1'b0, 5'b00011, 5'b00000, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{1'b1, 5'b01010, 5'b10110, 1'b0, 1'b0, 3'd2};
        tbl[5] = '{1'b0, 5'b01010, 5'b01010, 1'b1, 1'b0, 3'd2};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].new_game) start_game(tbl[i].code);
            press_guess(tbl[i].guess);
            chk($sformatf("vec%0d_success", i), int'(success), int'(tbl[i].exp_success));
            chk($sformatf("vec%0d_fail", i), int'(fail), int'(tbl[i].exp_fail));
            chk($sformatf("vec%0d_wrong", i), int'(wrong), 0);
            chk($sformatf("vec%0d_tries", i), int'(tries_left), int'(tbl[i].exp_tries));
        end

        // WIN ignores time_up; dropping start_input clears on the next edge.
        start_game(5'b10110);
        press_guess(5'b10110);
        time_up = 1'b1;
        repeat (3) tick();
        chk("win_ignores_timeup", int'({success, fail}), 2);
        time_up     = 1'b0;
        start_input = 1'b0;
        tick();
        chk("drop_clears_success", int'(success), 0);
        chk("drop_restores_tries", int'(tries_left), 3);

        // Bouncing press: exactly one check and one decrement.
        start_game(5'b00011);
        sw = 5'b00000;
        for (int i = 0; i < 12; i++) begin
            btn_confirm = (i % 2 == 0);
            tick();
        end
        chk("bounce_no_early_check", int'(tries_left), 3);
        btn_confirm = 1'b1;
        dec_cnt = 0;
        wr_rise = 0;
        prev_t  = tries_left;
        prev_w  = wrong;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tries_left != prev_t) dec_cnt++;
            if (wrong && !prev_w) wr_rise++;
            prev_t = tries_left;
            prev_w = wrong;
        end
        btn_confirm = 1'b0;
        repeat (10) tick();
        chk("bounce_decrements", dec_cnt, 1);
        chk("bounce_wrong_pulses", wr_rise, 1);
        chk("bounce_tries", int'(tries_left), 2);

        // time_up in the same cycle as the press pulse.
        start_game(5'b00011);
        sw          = 5'b00000;
        btn_confirm = 1'b1;
        repeat (6) tick();
        time_up = 1'b1;
        tick();
        chk("timeup_press_fail", int'({success, fail}), 1);
        chk("timeup_press_tries", int'(tries_left), 3);
        time_up     = 1'b0;
        btn_confirm = 1'b0;
        repeat (10) tick();
        chk("lose_terminal", int'({success, fail, wrong}), 2);

        // Reset during LOSE.
        rst_n = 1'b0;
        tick();
        chk("midgame_reset_flags", int'({success, fail, wrong}), 0);
        chk("midgame_reset_tries", int'(tries_left), 3);
        rst_n = 1'b1;

        // time_up during WRONG.
        start_game(5'b00011);
        sw          = 5'b00000;
        btn_confirm = 1'b1;
        repeat (6) tick();
        btn_confirm = 1'b0;
        repeat (2) tick();
        chk("wrong_before_timeup", int'(wrong), 1);
        repeat (2) tick();
        time_up = 1'b1;
        tick();
        chk("timeup_wrong_flags", int'({success, fail, wrong}), 2);
        chk("timeup_wrong_tries", int'(tries_left), 2);
        time_up = 1'b0;
        repeat (10) tick();

`ifdef CODE_CHECK_HINT_EN
        start_game(5'b10000);
        press_guess(5'b00100);
        press_guess(5'b11000);
`endif

        // Randomized games against the rule model.
        for (int gme = 0; gme < 12; gme++) begin
            start_game(5'($urandom_range(0, 31)));
            while (!m_done) begin
                if ($urandom_range(0, 3) == 0) rg = m_code;
                else rg = 5'($urandom_range(0, 31));
                press_guess(rg);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_check.md
Name: code_check

Overview:
- Password input/verification stage, directly downstream of the game control block; enabled by that block's startInput level.
- Latches the 5-bit secret code and accepts player guesses from switches plus a confirm button.
- Raises success or fail; these feed the control block's insuccess/infail inputs.
- Also reacts to time_up from the 20 s countdown.

Parameters:
- MAX_TRIES, 3, wrong guesses allowed before fail (1..7).
- DEBOUNCE_CYCLES, 20'd500000, stable clk cycles required to accept a button level change (10 ms at 50 MHz).
- FLASH_CYCLES, 24'd12500000, duration of the wrong-guess indication.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start_input  in  1  enable level from control (startInput); 0 forces IDLE
- code  in  5  secret code (control's random); sampled on the start_input rising edge
- sw  in  5  player guess, SW4..SW0
- btn_confirm  in  1  raw confirm button, active-high, bouncing
- time_up  in  1  countdown expired, level
- success  out  1  code matched; held until leave
- fail  out  1  tries exhausted or timeout; held until leave
- wrong  out  1  high for FLASH_CYCLES after a wrong guess
- tries_left  out  3  remaining attempts

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, success=0, fail=0, wrong=0, tries_left=MAX_TRIES, latched code=0, debouncer cleared to "released".
- Confirm path: btn_confirm passes a 2-flop synchronizer, then the debouncer. The output toggles only after DEBOUNCE_CYCLES consecutive equal samples. A one-cycle press pulse is generated on the debounced 0->1 edge.
- States: IDLE, ARMED, CHECK, WRONG, WIN, LOSE.
- IDLE:
  - Outputs low; tries_left=MAX_TRIES.
  - On start_input 0->1 (registered edge): latch code, go to ARMED.
  - If start_input is already high out of reset, treat it as a rising edge on the first cycle.
- ARMED:
  - time_up=1 -> LOSE (priority over press in the same cycle).
  - press -> CHECK, with sw registered as guess in the same cycle.
- CHECK (exactly one cycle):
  - guess==latched code -> WIN.
  - Otherwise tries_left decrements. If the new value is 0 -> LOSE, else -> WRONG.
- WRONG:
  - wrong=1 and a flash counter runs.
  - On expiry -> ARMED.
  - Presses are ignored.
  - time_up -> LOSE immediately; wrong drops the same cycle.
- WIN: success=1. LOSE: fail=1. Both are terminal; they exit only via start_input=0 or reset.
- Latency:
  - Debounced press to success/fail is 2 clk cycles (CHECK registered, then state output).
  - Outputs are registered and decoded from state.
- start_input falling in any state -> IDLE on the next edge; all outputs clear and counters reset. This mirrors control dropping startInput on infail/insuccess.
- time_up in WIN is ignored; success keeps priority.
- tries_left never underflows; it saturates at 0.
- success and fail are never both 1.

Optional Feature:
- Macro: CODE_CHECK_HINT_EN.
- Defined:
  - Adds output hint[1:0], registered in CHECK on a wrong guess: 2'b01 guess<code, 2'b10 guess>code (unsigned 5-bit compare).
  - Cleared to 0 on leaving WRONG, in IDLE, and on reset.
- Undefined: no hint port and no comparator logic. All other behaviour is identical.

Decomposition:
- Shared package game_pkg:
  - State enum constants for code_check.
  - CODE_W=5.
  - Clock-frequency-derived constants (CLK_HZ=50_000_000, MS_CYCLES).
- One sub-module, btn_debounce: synchronizer, stable counter, edge pulse; parameter DEBOUNCE_CYCLES. The same block is reused for the control block's BTN1.

Test Plan (DEBOUNCE_CYCLES=4, FLASH_CYCLES=8):
1. Reset then start_input 0->1 with code=5'b10110; sw=5'b10110; clean press of 6 cycles -> success=1 within 2 cycles of the debounced edge; tries_left=3; fail=0.
2. code=5'b00011; guesses 5'b00001, 5'b11111, 5'b00000 -> wrong pulses 8 cycles after each of the first two; tries_left 2,1,0; fail=1 after the third; wrong=0.
3. Bouncing press (1-cycle glitches every 2 cycles for 12 cycles, then stable high) -> exactly one CHECK and one decrement.
4. time_up=1 in ARMED in the same cycle as the press pulse -> LOSE, fail=1, tries_left unchanged at 3. time_up during WRONG -> fail next cycle, wrong=0.
5. In WIN: drop start_input -> next cycle success=0, state IDLE, tries_left=3. Re-raise with a new code=5'b01010 -> the old code no longer matches and the new one does.
6. CODE_CHECK_HINT_EN, code=5'b10000: guess 5'b00100 -> hint=01; guess 5'b11000 -> hint=10; hint=0 after the flash. Build without the macro -> no hint port elaborates.
